pc_sequencer: RTL

Owns the 30-bit word-addressed program counter and sequences instruction fetch over a req/ack handshake with instruction memory. Accepts redirect commands from decode/execute: branch (PC+1+sign-extended 16-bit offset), jump (26-bit pseudo-direct), jump-register and halt. Computes next-address targets internally and handles stall and in-flight fetches. Sits between the instruction memory port and the decode stage.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_next_addr_calc.sv | 41 ++++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared encodings for the program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        RD_BRANCH = 2'b00,
        RD_JUMP   = 2'b01,
        RD_JR     = 2'b10,
        RD_HALT   = 2'b11
    } redir_t;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        STALL = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [29:0] DEFAULT_RESET_PC = 30'h0;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_next_addr_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_addr_calc
// Description : Redirect target arithmetic relative to the last delivered PC.
// Revision    : 1.0 - initial release
// ============================================================================
module next_addr_calc
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W  = 30,
    parameter int OFF_W = 16
) (
    input  logic [PC_W-1:0]  pc_out,
    input  logic [1:0]       redir_type,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [25:0]      jmp_target,
    input  logic [31:0]      jr_addr,
    output logic [PC_W-1:0]  target,
    output logic             misaligned_c
);

    logic [PC_W-1:0] p1;
    logic [PC_W-1:0] off_se;

    assign p1     = pc_out + PC_W'(1);
    assign off_se = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};

    always_comb begin
        target = p1;
        case (redir_type)
            RD_BRANCH: target = p1 + off_se;
            RD_JUMP:   target = {p1[PC_W-1:26], jmp_target};
            RD_JR:     target = jr_addr[PC_W+1:2];
            default:   target = p1;
        endcase
    end

    assign misaligned_c = (redir_type == RD_JR) && (jr_addr[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter and instruction-fetch sequencer with redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = 30,
    parameter int              OFF_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [1:0]       redir_type,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [25:0]      jmp_target,
    input  logic [31:0]      jr_addr,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    output logic             inst_valid,
    output logic [PC_W-1:0]  pc_out,
    output logic             halted,
    output logic             misaligned
);

    state_t          state, state_nx;
    logic [PC_W-1:0] pc, pc_nx;
    logic [PC_W-1:0] pend_tgt, pend_tgt_nx;
    logic            pend_v, pend_v_nx;
    logic            pend_halt, pend_halt_nx;
    logic            inst_valid_nx;
    logic [PC_W-1:0] pc_out_nx;
    logic            misaligned_nx;
    logic [PC_W-1:0] target;
    logic            misaligned_c;
    logic            is_halt;

    next_addr_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next_addr_calc (
        .pc_out       (pc_out),
        .redir_type   (redir_type),
        .br_offset    (br_offset),
        .jmp_target   (jmp_target),
        .jr_addr      (jr_addr),
        .target       (target),
        .misaligned_c (misaligned_c)
    );

    assign is_halt = (redir_type == RD_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pend_v     <= 1'b0;
            pend_halt  <= 1'b0;
            pend_tgt   <= '0;
            inst_valid <= 1'b0;
            pc_out     <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            pend_v     <= pend_v_nx;
            pend_halt  <= pend_halt_nx;
            pend_tgt   <= pend_tgt_nx;
            inst_valid <= inst_valid_nx;
            pc_out     <= pc_out_nx;
            misaligned <= misaligned_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        pend_v_nx     = pend_v;
        pend_halt_nx  = pend_halt;
        pend_tgt_nx   = pend_tgt;
        inst_valid_nx = 1'b0;
        pc_out_nx     = pc_out;
        misaligned_nx = 1'b0;

        case (state)
            BOOT: begin
                state_nx = FETCH;
            end
            FETCH: begin
                misaligned_nx = redir_valid && misaligned_c;
                if (imem_ack) begin
                    // A redirect arriving with the ack takes priority over a pending one.
                    if (redir_valid || pend_v) begin
                        pend_v_nx = 1'b0;
                        if (redir_valid ? is_halt : pend_halt) begin
                            state_nx = HALT;
                        end else begin
                            pc_nx    = redir_valid ? target : pend_tgt;
                            state_nx = stall ? STALL : FETCH;
                        end
                    end else begin
                        inst_valid_nx = 1'b1;
                        pc_out_nx     = pc;
                        pc_nx         = pc + PC_W'(1);
                        state_nx      = stall ? STALL : FETCH;
                    end
                end else if (redir_valid) begin
                    pend_v_nx    = 1'b1;
                    pend_tgt_nx  = target;
                    pend_halt_nx = is_halt;
                end
            end
            STALL: begin
                misaligned_nx = redir_valid && misaligned_c;
                if (redir_valid && is_halt) begin
                    state_nx = HALT;
                end else begin
                    if (redir_valid) begin
                        pc_nx = target;
                    end
                    if (!stall) begin
                        state_nx = FETCH;
                    end
                end
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

endmodule
`default_nettype wire
